// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers one payload, then sends header,
// payload and XOR parity to the router under its busy back-pressure.
module router_pkt_tx #(
    parameter int unsigned IDLE_GAP = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  dest_addr,
    input  logic [5:0]  pkt_len,
    output logic        ready,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic        busy,
    output logic [7:0]  tx_data,
    output logic        pkt_valid,
    output logic        done,
    output logic        req_err,
    output logic [15:0] pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

    state_t      state_q, state_d;
    logic [1:0]  addr_q, addr_d;
    logic [5:0]  len_q, len_d;
    logic [5:0]  wr_ptr_q, wr_ptr_d;
    logic [5:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]  parity_q, parity_d;
    logic [3:0]  gap_q, gap_d;
    logic [15:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        req_err_q, req_err_d;
    logic        buf_we;

    logic [7:0]  buf_mem [64];
    logic [7:0]  header;
    logic [7:0]  rd_byte;

    assign header  = {len_q, addr_q};
    assign rd_byte = buf_mem[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        parity_d  = parity_q;
        gap_d     = gap_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        req_err_d = 1'b0;
        buf_we    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dest_addr != 2'd3 && pkt_len != 6'd0) begin
                        addr_d   = dest_addr;
                        len_d    = pkt_len;
                        wr_ptr_d = 6'd0;
                        state_d  = S_LOAD;
                    end else begin
                        req_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (pl_valid) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 6'd1;
                    if (wr_ptr_q == len_q - 6'd1) begin
                        state_d = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    parity_d = header;
                    rd_ptr_d = 6'd0;
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    parity_d = parity_q ^ rd_byte;
                    rd_ptr_d = rd_ptr_q + 6'd1;
                    if (rd_ptr_q == len_q - 6'd1) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    gap_d   = 4'd0;
                    state_d = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                gap_d = gap_q + 4'd1;
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= 2'd0;
            len_q     <= 6'd0;
            wr_ptr_q  <= 6'd0;
            rd_ptr_q  <= 6'd0;
            parity_q  <= 8'h00;
            gap_q     <= 4'd0;
            cnt_q     <= 16'd0;
            done_q    <= 1'b0;
            req_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            parity_q  <= parity_d;
            gap_q     <= gap_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            req_err_q <= req_err_d;
        end
    end

    // Payload storage is not reset; stale bytes are never read back.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buf_mem[wr_ptr_q] <= pl_data;
        end
    end

    always_comb begin
        tx_data   = 8'h00;
        pkt_valid = 1'b0;
        unique case (state_q)
            S_HEADER: begin
                tx_data   = header;
                pkt_valid = 1'b1;
            end
            S_PAYLOAD: begin
                tx_data   = rd_byte;
                pkt_valid = 1'b1;
            end
            S_PARITY: tx_data = parity_q;
            default: ;
        endcase
    end

    assign ready    = (state_q == S_IDLE);
    assign pl_ready = (state_q == S_LOAD);
    assign done     = done_q;
    assign req_err  = req_err_q;
    assign pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed and randomized bench for router_pkt_tx with an in-bench
// packet-level model (expected byte stream built from header/payload/XOR).
module tb_router_pkt_tx;

    localparam int unsigned GAP = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  dest_addr = 2'd0;
    logic [5:0]  pkt_len = 6'd0;
    logic        ready;
    logic [7:0]  pl_data = 8'h00;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic        busy = 1'b0;
    logic [7:0]  tx_data;
    logic        pkt_valid;
    logic        done;
    logic        req_err;
    logic [15:0] pkt_cnt;

    int total = 0;
    int failed = 0;

    logic [1:0]  m_addr;
    logic [5:0]  m_len;
    logic [7:0]  pl [64];
    logic [15:0] exp_cnt = 16'd0;

    router_pkt_tx #(.IDLE_GAP(GAP)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .dest_addr(dest_addr),
        .pkt_len(pkt_len),
        .ready(ready),
        .pl_data(pl_data),
        .pl_valid(pl_valid),
        .pl_ready(pl_ready),
        .busy(busy),
        .tx_data(tx_data),
        .pkt_valid(pkt_valid),
        .done(done),
        .req_err(req_err),
        .pkt_cnt(pkt_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; DUT in IDLE on entry, HEADER on exit.
    task automatic load_pkt(input logic [1:0] a, input logic [5:0] l,
                            input int vmode);
        int k;
        int cyc;
        m_addr = a;
        m_len  = l;
        chk("ready_idle", ready, 1);
        start = 1'b1;
        dest_addr = a;
        pkt_len = l;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        chk("ready_load", ready, 0);
        k = 0;
        cyc = 0;
        while (k < int'(l) && cyc < 2000) begin
            case (vmode)
                0: pl_valid = 1'b1;
                1: pl_valid = (cyc % 2 == 0);
                default: pl_valid = 1'($urandom_range(0, 1));
            endcase
            pl_data = pl[k];
            start = 1'($urandom_range(0, 1));
            dest_addr = 2'd3;
            chk("pl_ready", pl_ready, 1);
            chk("req_err_ignored", req_err, 0);
            chk("load_pkt_valid", pkt_valid, 0);
            @(posedge clock);
            if (pl_valid) k++;
            cyc++;
            @(negedge clock);
        end
        pl_valid = 1'b0;
        start = 1'b0;
        chk("load_count", k, int'(l));
    endtask

    // Sends up to nbytes of the expected stream; full packet if nbytes<0.
    task automatic tx_pkt(input int bmode, input int nbytes);
        logic [7:0] e [66];
        logic [7:0] par;
        int n;
        int att;
        int g;
        e[0] = {m_len, m_addr};
        par = e[0];
        for (int j = 0; j < int'(m_len); j++) begin
            e[j + 1] = pl[j];
            par = par ^ pl[j];
        end
        e[int'(m_len) + 1] = par;
        n = (nbytes < 0) ? int'(m_len) + 2 : nbytes;
        for (int i = 0; i < n; i++) begin
            att = 0;
            do begin
                case (bmode)
                    0: busy = 1'b0;
                    1: busy = ($urandom_range(0, 3) == 0);
                    default: busy = (i == 1 && att < 3);
                endcase
                if (att > 100) busy = 1'b0;
                chk("tx_data", tx_data, e[i]);
                chk("pkt_valid", pkt_valid, (i <= int'(m_len)) ? 1 : 0);
                chk("done_low", done, 0);
                @(posedge clock);
                att++;
                @(negedge clock);
            end while (busy);
            if (bmode == 2 && i == 1) chk("hold_cycles", att, 4);
        end
        busy = 1'b0;
        if (nbytes >= 0) return;
        exp_cnt = exp_cnt + 16'd1;
        chk("done_pulse", done, 1);
        chk("pkt_cnt", pkt_cnt, exp_cnt);
        g = 0;
        while (!ready && g < 50) begin
            chk("gap_tx", tx_data, 0);
            chk("gap_valid", pkt_valid, 0);
            @(posedge clock);
            @(negedge clock);
            g++;
        end
        chk("gap_len", g, GAP);
        chk("done_once", done, 0);
    endtask

    task automatic illegal(input logic [1:0] a, input logic [5:0] l);
        start = 1'b1;
        dest_addr = a;
        pkt_len = l;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        chk("req_err_pulse", req_err, 1);
        chk("req_err_ready", ready, 1);
        chk("req_err_valid", pkt_valid, 0);
        @(posedge clock);
        @(negedge clock);
        chk("req_err_clear", req_err, 0);
        chk("req_err_ready2", ready, 1);
        chk("req_err_pl_ready", pl_ready, 0);
    endtask

    initial begin
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_pl_ready", pl_ready, 0);
        chk("rst_tx", tx_data, 0);
        chk("rst_valid", pkt_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_req_err", req_err, 0);
        chk("rst_cnt", pkt_cnt, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        pl[0] = 8'h11;
        pl[1] = 8'h22;
        pl[2] = 8'h33;
        load_pkt(2'd1, 6'd3, 0);
        chk("hdr_0d", tx_data, 8'h0D);
        tx_pkt(0, -1);

        for (int j = 0; j < 5; j++) pl[j] = 8'($urandom);
        load_pkt(2'd0, 6'd5, 0);
        tx_pkt(2, -1);

        illegal(2'd3, 6'd4);
        illegal(2'd1, 6'd0);

        for (int j = 0; j < 63; j++) pl[j] = 8'($urandom);
        load_pkt(2'd2, 6'd63, 1);
        tx_pkt(0, -1);

        for (int p = 0; p < 6; p++) begin
            for (int j = 0; j < 64; j++) pl[j] = 8'($urandom);
            load_pkt(2'($urandom_range(0, 2)), 6'($urandom_range(1, 20)), 2);
            tx_pkt(1, -1);
        end

        for (int j = 0; j < 8; j++) pl[j] = 8'($urandom);
        load_pkt(2'd1, 6'd8, 0);
        tx_pkt(0, 3);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", pkt_valid, 0);
        chk("mid_rst_tx", tx_data, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = 16'd0;
        chk("mid_rst_cnt", pkt_cnt, 0);
        @(negedge clock);
        chk("mid_rst_no_done", done, 0);

        pl[0] = 8'hA5;
        load_pkt(2'd2, 6'd1, 0);
        chk("hdr_06", tx_data, 8'h06);
        tx_pkt(0, -1);

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end

endmodule
